alarm_ctrl: RTL and testbench

Alarm sequencer for the 4-digit counter display. It holds a programmable alarm time and detects when the live BCD digits reach it. On a match it drives the active buzzer with a timed on/off beep pattern. It also handles arm/disarm, acknowledge, ring timeout and an optional snooze.

---
 rtl/alarm_ctrl.sv | 162 ++++++++++++++++
 tb/tb_alarm_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm-time compare, ring/snooze sequencer and timed beep generator.
// Define ALARM_SNOOZE_EN to build the snooze input, the SNOOZE state and the snooze limit.
module alarm_ctrl #(
   parameter int BEEP_ON       = 4,
   parameter int BEEP_OFF      = 4,
   parameter int RING_CYCLES   = 64,
   parameter int SNOOZE_CYCLES = 32,
   parameter int MAX_SNOOZE    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  d0,
   input  logic [3:0]  d1,
   input  logic [3:0]  d2,
   input  logic [3:0]  d3,
   input  logic        arm,
   input  logic        disarm,
   input  logic        set_en,
   input  logic [15:0] set_val,
   input  logic        ack,
`ifdef ALARM_SNOOZE_EN
   input  logic        snooze,
`endif
   output logic        buzzer,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_RINGING = 2'd2,
      S_SNOOZE  = 2'd3
   } state_t;

   localparam int PHASE_N = BEEP_ON + BEEP_OFF;
   localparam int RW      = $clog2(RING_CYCLES + 1);
   localparam int PW      = $clog2(PHASE_N + 1);
   localparam logic [RW-1:0] RING_LAST  = RW'(RING_CYCLES - 1);
   localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_N - 1);
   localparam logic [PW-1:0] PHASE_ON   = PW'(BEEP_ON);

   state_t        st;
   logic [15:0]   alarm_time;
   logic          match_q;
   logic [RW-1:0] ring_cnt;
   logic [PW-1:0] phase;
   logic          match;
   logic          match_edge;
   logic          ring_done;
   logic          in_alert;

   // Edge detect so a display parked on the alarm time fires only once.
   assign match      = ({d3, d2, d1, d0} == alarm_time);
   assign match_edge = match & ~match_q;
   assign ring_done  = (ring_cnt == RING_LAST);
   assign in_alert   = (st == S_RINGING) || (st == S_SNOOZE);
   assign state      = st;

`ifdef ALARM_SNOOZE_EN
   localparam int SW = $clog2(SNOOZE_CYCLES + 1);
   localparam int CW = $clog2(MAX_SNOOZE + 1);
   localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_CYCLES - 1);
   localparam logic [CW-1:0] SNZ_MAX  = CW'(MAX_SNOOZE);

   logic [SW-1:0] snz_cnt;
   logic [CW-1:0] snooze_count;
   logic          snz_done;
   logic          snooze_ok;

   assign snz_done  = (snz_cnt == SNZ_LAST);
   assign snooze_ok = snooze && (st == S_RINGING) && (snooze_count < SNZ_MAX);
`else
   logic unused_cfg;
   assign unused_cfg = (SNOOZE_CYCLES > 0) ^ (MAX_SNOOZE > 0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st           <= S_IDLE;
         buzzer       <= 1'b0;
         alarm_time   <= 16'h0010;
         match_q      <= 1'b1;
         ring_cnt     <= '0;
         phase        <= '0;
`ifdef ALARM_SNOOZE_EN
         snz_cnt      <= '0;
         snooze_count <= '0;
`endif
      end else begin
         // Loading the alarm time masks a match against the current display.
         match_q <= set_en ? 1'b1 : match;
         if (set_en) begin
            alarm_time <= set_val;
         end

         buzzer <= (st == S_RINGING) && (phase < PHASE_ON);

         if (st == S_RINGING) begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
            if (!ring_done) begin
               ring_cnt <= ring_cnt + 1'b1;
            end
         end
`ifdef ALARM_SNOOZE_EN
         if ((st == S_SNOOZE) && !snz_done) begin
            snz_cnt <= snz_cnt + 1'b1;
         end
`endif

         if (disarm) begin
            st <= S_IDLE;
         end else if (set_en) begin
            if (in_alert) begin
               st <= S_ARMED;
            end
         end else if (ack && in_alert) begin
            st <= S_ARMED;
`ifdef ALARM_SNOOZE_EN
         end else if (snooze_ok) begin
            st           <= S_SNOOZE;
            snz_cnt      <= '0;
            snooze_count <= snooze_count + 1'b1;
`endif
         end else begin
            case (st)
               S_IDLE: begin
                  if (arm) begin
                     st <= S_ARMED;
                  end
               end
               S_ARMED: begin
                  if (match_edge) begin
                     st       <= S_RINGING;
                     ring_cnt <= '0;
                     phase    <= '0;
`ifdef ALARM_SNOOZE_EN
                     snooze_count <= '0;
`endif
                  end
               end
               S_RINGING: begin
                  if (ring_done) begin
                     st <= S_ARMED;
                  end
               end
`ifdef ALARM_SNOOZE_EN
               S_SNOOZE: begin
                  // Re-ring restarts the ring window and beeps from the high half.
                  if (snz_done) begin
                     st       <= S_RINGING;
                     ring_cnt <= '0;
                     phase    <= '0;
                  end
               end
`endif
               default: st <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios then random stimulus against a cycle model.
// Build with ALARM_SNOOZE_EN defined to also cover snooze behaviour.
module tb_alarm_ctrl;

   localparam int BEEP_ON       = 4;
   localparam int BEEP_OFF      = 4;
   localparam int RING_CYCLES   = 64;
   localparam int SNOOZE_CYCLES = 32;
   localparam int MAX_SNOOZE    = 3;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ_BUILD = 1'b1;
`else
   localparam bit SNZ_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] disp;
   logic        arm, disarm, set_en, ack, snooze;
   logic [15:0] set_val;
   logic        buzzer;
   logic [1:0]  dut_state;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: state number plus cycles spent in the current ring/snooze visit.
   int          m_state;
   logic [15:0] m_alarm;
   bit          m_prev;
   int          m_age;
   int          m_snz_age;
   int          m_snoozes;
   bit          m_buzzer;

   always #5 clk = ~clk;

   alarm_ctrl #(
      .BEEP_ON(BEEP_ON), .BEEP_OFF(BEEP_OFF), .RING_CYCLES(RING_CYCLES),
      .SNOOZE_CYCLES(SNOOZE_CYCLES), .MAX_SNOOZE(MAX_SNOOZE)
   ) dut (
      .clk(clk), .rst(rst),
      .d0(disp[3:0]), .d1(disp[7:4]), .d2(disp[11:8]), .d3(disp[15:12]),
      .arm(arm), .disarm(disarm), .set_en(set_en), .set_val(set_val), .ack(ack),
`ifdef ALARM_SNOOZE_EN
      .snooze(snooze),
`endif
      .buzzer(buzzer), .state(dut_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_state   = 0;
      m_alarm   = 16'h0010;
      m_prev    = 1'b1;
      m_age     = 0;
      m_snz_age = 0;
      m_snoozes = 0;
      m_buzzer  = 1'b0;
   endtask

   task automatic model_tick();
      bit hit, rise, alert;
      int ns;
      hit   = (disp == m_alarm);
      rise  = hit && !m_prev;
      alert = (m_state == 2) || (m_state == 3);
      m_buzzer = (m_state == 2) && ((m_age % (BEEP_ON + BEEP_OFF)) < BEEP_ON);
      ns = m_state;
      if (disarm) ns = 0;
      else if (set_en) ns = alert ? 1 : m_state;
      else if (ack && alert) ns = 1;
      else if (SNZ_BUILD && snooze && m_state == 2 && m_snoozes < MAX_SNOOZE) begin
         ns = 3;
         m_snoozes++;
      end
      else if (m_state == 0 && arm) ns = 1;
      else if (m_state == 1 && rise) begin
         ns = 2;
         m_snoozes = 0;
      end
      else if (m_state == 2 && m_age == RING_CYCLES - 1) ns = 1;
      else if (m_state == 3 && m_snz_age == SNOOZE_CYCLES - 1) ns = 2;
      if (ns == 2) m_age = (m_state == 2) ? m_age + 1 : 0;
      if (ns == 3) m_snz_age = (m_state == 3) ? m_snz_age + 1 : 0;
      m_prev = set_en ? 1'b1 : hit;
      if (set_en) m_alarm = set_val;
      m_state = ns;
   endtask

   task automatic step();
      @(posedge clk);
      model_tick();
      #1;
      check("state", dut_state, m_state);
      check("buzzer", buzzer, m_buzzer);
      arm = 0; disarm = 0; set_en = 0; ack = 0; snooze = 0;
   endtask

   task automatic ring_via(input logic [15:0] away, input logic [15:0] hit);
      disp = away;
      step();
      disp = hit;
      step();
   endtask

   task automatic count_while(input int st_val, output int n);
      n = 0;
      while (dut_state == 2'(st_val) && n < 200) begin
         step();
         n++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int r;
      disp = 16'h0000; set_val = 16'h0000;
      arm = 0; disarm = 0; set_en = 0; ack = 0; snooze = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", dut_state, 0);
      check("rst_buzzer", buzzer, 0);
      rst = 1;

      // Arm, ramp the display up to the reset alarm time, full ring to timeout.
      arm = 1; step();
      for (int i = 0; i <= 10; i++) begin
         disp = (i == 10) ? 16'h0010 : 16'(i);
         step();
      end
      check("ring_enter", dut_state, 2);
      step();
      check("first_beep", buzzer, 1);
      count_while(2, n);
      check("ring_len", n + 1, RING_CYCLES);
      check("ring_timeout", dut_state, 1);
      step();
      check("buzzer_after_timeout", buzzer, 0);

      // Loading the currently displayed time must not ring.
      disarm = 1; step();
      disp = 16'h0105; set_val = 16'h0105; set_en = 1; step();
      arm = 1; step();
      repeat (5) step();
      check("no_ring_on_load", dut_state, 1);
      ring_via(16'h0106, 16'h0105);
      check("ring_reentry", dut_state, 2);

      // Ack on the tenth ringing cycle; held display must not re-trigger.
      repeat (9) step();
      ack = 1; step();
      check("ack_state", dut_state, 1);
      step();
      check("ack_buzzer", buzzer, 0);
      repeat (10) step();
      check("no_retrigger", dut_state, 1);

`ifdef ALARM_SNOOZE_EN
      ring_via(16'h0106, 16'h0105);
      check("snz_ring", dut_state, 2);
      for (int k = 0; k < MAX_SNOOZE; k++) begin
         repeat (3) step();
         snooze = 1; step();
         check("snooze_enter", dut_state, 3);
         count_while(3, n);
         check("snooze_len", n, SNOOZE_CYCLES);
         check("rering", dut_state, 2);
         step();
         check("rering_beep", buzzer, 1);
      end
      snooze = 1; step();
      check("snooze_limit", dut_state, 2);
      count_while(2, n);
      check("final_timeout", dut_state, 1);
`endif

      // Disarm beats ack; a later match is ignored until re-armed.
      ring_via(16'h0106, 16'h0105);
      check("ring_for_disarm", dut_state, 2);
      repeat (2) step();
      disarm = 1; ack = 1; step();
      check("disarm_state", dut_state, 0);
      step();
      check("disarm_buzzer", buzzer, 0);
      ring_via(16'h0106, 16'h0105);
      check("idle_ignores_match", dut_state, 0);
      arm = 1; step();
      repeat (3) step();
      check("armed_no_stale", dut_state, 1);
      ring_via(16'h0106, 16'h0105);
      check("rearm_ring", dut_state, 2);

      // Asynchronous reset mid-ring; alarm time returns to 0010.
      repeat (5) step();
      #2;
      rst = 0;
      #1;
      check("async_rst_state", dut_state, 0);
      check("async_rst_buzzer", buzzer, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1;
      arm = 1; step();
      ring_via(16'h0106, 16'h0105);
      check("old_alarm_gone", dut_state, 1);
      ring_via(16'h0009, 16'h0010);
      check("alarm_reverted", dut_state, 2);

      // Random traffic around the alarm time.
      for (int c = 0; c < 3000; c++) begin
         r = $urandom_range(0, 99);
         if (r < 40)      disp = m_alarm;
         else if (r < 75) disp = m_alarm ^ 16'(1 << $urandom_range(0, 3));
         else if (r < 90) disp = 16'h0010;
         else             disp = 16'($urandom_range(0, 16'hffff));
         arm    = ($urandom_range(0, 99) < 15);
         disarm = ($urandom_range(0, 99) < 2);
         set_en = ($urandom_range(0, 99) < 3);
         ack    = ($urandom_range(0, 99) < 3);
         snooze = SNZ_BUILD && ($urandom_range(0, 99) < 8);
         r = $urandom_range(0, 2);
         set_val = (r == 0) ? disp : (r == 1) ? (disp ^ 16'h0001) : 16'h0010;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
